wb_gpio_irq: RTL and testbench
==============================

# wb_gpio_irq

Parametrised Wishbone GPIO peripheral with per-pin direction, debounced synchronised inputs and edge-triggered interrupts. It generalises the fixed 8-bit button/LED GPIO to WIDTH pins, adds a latched interrupt status register with write-1-to-clear semantics, and drives a single level interrupt line to the CPU interrupt controller. Pin tristating is done at the top level from gpio_o/gpio_oe.

## Interface
- WIDTH, 8: number of GPIO pins, 1..32.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles before an input change is accepted, 1..65535.
- DIR_RESET, 0: reset value of DIR (WIDTH bits).
- OUT_RESET, 0: reset value of DATA_OUT (WIDTH bits).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- wb_adr_i  in  32  byte address; only [4:2] decoded.
- wb_dat_i  in  32  write data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  registered read data.
- gpio_i  in  WIDTH  asynchronous pin inputs.
- gpio_o  out  WIDTH  output values (= DATA_OUT).
- gpio_oe  out  WIDTH  output enables (= DIR; 1 = drive).
- irq_o  out  1  level interrupt, |(STATUS & MASK).

## Operation
- Register map (adr[4:2]): 0 DATA_IN (RO, debounced input), 1 DATA_OUT (RW), 2 DIR (RW), 3 MASK (RW), 4 RISE_EN (RW), 5 FALL_EN (RW), 6 STATUS (RW1C), 7 reserved (reads 0, writes ignored).
- Only bits [WIDTH-1:0] exist; upper bits read 0, writes ignored. DATA_IN reads the debounced input regardless of DIR.
- Input path per pin: 2-flop synchroniser -> debounce counter -> stable register. The counter increments while sync != stable and clears when sync == stable. When sync != stable and count == DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
- Edge detect on stable: STATUS[i] sets on a stable 0->1 change with RISE_EN[i], or on a 1->0 change with FALL_EN[i]. STATUS latches independent of MASK. MASK gates only irq_o.
- STATUS write: bits written 1 clear; bits written 0 are unchanged. If a set and a clear hit the same bit in the same cycle, the set wins.
- Reset values: DATA_OUT=OUT_RESET, DIR=DIR_RESET, MASK/RISE_EN/FALL_EN/STATUS=0, sync/stable/counters=0, wb_ack_o=0, wb_dat_o=0, irq_o=0.

## Timing
- Bus: with stb&cyc high and ack low, ack goes high on the next edge for exactly one cycle, then low for at least one cycle. Each access takes 2 cycles minimum. wb_ack_o is gated by stb&cyc.
- Read data is registered on the same edge that raises ack. wb_dat_o holds its value until the next read.
- Write takes effect on the ack edge. gpio_o/gpio_oe/irq_o reflect it in the same cycle that ack is high.
- Input latency: a gpio_i change stable before edge 0 reaches sync at edge 1 and stable/DATA_IN at edge 1+DEBOUNCE_CYCLES. STATUS sets on that same edge. irq_o is combinational from registers, so it is high in the following cycle.
- Pulses on sync shorter than DEBOUNCE_CYCLES cycles produce no DATA_IN change and no STATUS set.
- Reset mid-access: ack drops on the reset edge and the access is lost. The master must restart.
- A STATUS read concurrent with a new set returns the pre-set value. The set is not lost.

## Structure
- Package wb_gpio_pkg: register offset constants (ADDR_DATA_IN..ADDR_STATUS), and the register-index width constant (3).
- Sub-module gpio_in_cond (one instance per pin via generate): synchroniser, debounce counter, stable register, and rise/fall pulse outputs. Parameter: DEBOUNCE_CYCLES.
- Top module holds the Wishbone FSM (IDLE/ACK), the registers, the STATUS set/clear logic, and the irq reduction.

## Test plan
- Reset, then read all 8 addresses -> DATA_OUT=OUT_RESET, DIR=DIR_RESET, others 0, and address 7 reads 0. Each access sees ack high exactly 1 cycle.
- Write DATA_OUT=0xA5, DIR=0x0F (WIDTH=8) -> gpio_o=0xA5 and gpio_oe=0x0F in the ack cycle. Write 0xFFFF_FFFF to DATA_OUT, read back -> 0x0000_00FF.
- DEBOUNCE_CYCLES=4: raise gpio_i[2] at edge 0 -> DATA_IN bit 2 set at edge 5. A 3-cycle pulse on gpio_i[3] -> no change and STATUS stays 0.
- RISE_EN=0x04, MASK=0x04: raise gpio_i[2] -> STATUS=0x04 and irq_o=1. Write STATUS=0x04 -> STATUS=0 and irq_o=0. A falling edge produces no set.
- FALL_EN=0x01, MASK=0: falling edge on pin 0 -> STATUS=0x01 and irq_o=0. Write MASK=0x01 -> irq_o=1.
- STATUS W1C of bit 1 landing on the same edge as a new bit-1 set -> STATUS[1] remains 1. Assert rst during ack -> ack drops next cycle and all registers return to their reset values.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// wb_gpio_irq shared definitions
// Register offsets (adr[4:2]) and bus FSM states.
package wb_gpio_pkg;

    localparam int REG_IDX_W = 3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ADDR_DATA_IN  = 3'd0;
    localparam reg_idx_t ADDR_DATA_OUT = 3'd1;
    localparam reg_idx_t ADDR_DIR      = 3'd2;
    localparam reg_idx_t ADDR_MASK     = 3'd3;
    localparam reg_idx_t ADDR_RISE_EN  = 3'd4;
    localparam reg_idx_t ADDR_FALL_EN  = 3'd5;
    localparam reg_idx_t ADDR_STATUS   = 3'd6;
    localparam reg_idx_t ADDR_RSVD     = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } wb_state_e;

endpackage

// File: rtl/wb_gpio_irq_if.sv
// wb_gpio_irq Wishbone slave bundle
// Classic single-access Wishbone signals with master/slave views.
interface wb_gpio_irq_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_we_i,
        output wb_cyc_i,
        output wb_stb_i,
        input  wb_ack_o,
        input  wb_dat_o
    );

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_we_i,
        input  wb_cyc_i,
        input  wb_stb_i,
        output wb_ack_o,
        output wb_dat_o
    );

endinterface

// File: rtl/gpio_in_cond.sv
// wb_gpio_irq per-pin input conditioner
// Synchroniser, debounce counter, stable level and edge pulses.
module gpio_in_cond #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        stable_q;
    logic        stable_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        accept;

    // Count while the synchronised level disagrees; accept on the last count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
        if (sync2_q != stable_q) begin
            if (accept) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Synchroniser, counter and stable level state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Edge pulses coincide with the edge that updates the stable level.
    assign level_o = stable_q;
    assign rise_o  = accept & sync2_q;
    assign fall_o  = accept & ~sync2_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq top: Wishbone GPIO with edge interrupts
// Bus FSM, register file, W1C status and level irq.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] DIR_RESET       = '0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk,
    input  logic             rst,
    wb_gpio_irq_if.slave     wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    wb_state_e        state_q, state_d;
    logic             req;
    logic             acc;
    logic             wr;
    reg_idx_t         idx;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] sets;
    logic [31:0]      rd;
    logic [31:0]      dat_q, dat_d;

    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] rise_p;
    logic [WIDTH-1:0] fall_p;

    logic             unused_bits;

    assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], wb.wb_dat_i};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_in_cond #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk    (clk),
            .rst    (rst),
            .pin_i  (gpio_i[i]),
            .level_o(din[i]),
            .rise_o (rise_p[i]),
            .fall_o (fall_p[i])
        );
    end

    assign req   = wb.wb_cyc_i & wb.wb_stb_i;
    assign acc   = (state_q == ST_IDLE) & req;
    assign wr    = acc & wb.wb_we_i;
    assign idx   = wb.wb_adr_i[4:2];
    assign wdata = wb.wb_dat_i[WIDTH-1:0];

    // Bus FSM: one ack cycle per access, then back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Register writes and status update; a same-cycle set beats a clear.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        sets      = (rise_p & rise_en_q) | (fall_p & fall_en_q);
        if (wr) begin
            case (idx)
                ADDR_DATA_OUT: out_d     = wdata;
                ADDR_DIR:      dir_d     = wdata;
                ADDR_MASK:     mask_d    = wdata;
                ADDR_RISE_EN:  rise_en_d = wdata;
                ADDR_FALL_EN:  fall_en_d = wdata;
                ADDR_STATUS:   clr       = wdata;
                default:       ;
            endcase
        end
        status_d = (status_q & ~clr) | sets;
    end

    // Read mux; the registered copy is only refreshed by a read.
    always_comb begin
        rd = '0;
        case (idx)
            ADDR_DATA_IN:  rd[WIDTH-1:0] = din;
            ADDR_DATA_OUT: rd[WIDTH-1:0] = out_q;
            ADDR_DIR:      rd[WIDTH-1:0] = dir_q;
            ADDR_MASK:     rd[WIDTH-1:0] = mask_q;
            ADDR_RISE_EN:  rd[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:  rd[WIDTH-1:0] = fall_en_q;
            ADDR_STATUS:   rd[WIDTH-1:0] = status_q;
            ADDR_RSVD:     rd            = '0;
            default:       rd            = '0;
        endcase
        dat_d = (acc & ~wb.wb_we_i) ? rd : dat_q;
    end

    // State, register file and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            out_q     <= OUT_RESET;
            dir_q     <= DIR_RESET;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.wb_ack_o = (state_q == ST_ACK) & req;
    assign wb.wb_dat_o = dat_q;
    assign gpio_o      = out_q;
    assign gpio_oe     = dir_q;
    assign irq_o       = |(status_q & mask_q);

endmodule

// File: tb/tb_wb_gpio_irq.sv
// wb_gpio_irq testbench
// Register vectors, timing corner cases and a random model check.
module tb_wb_gpio_irq;

    localparam int          W     = 8;
    localparam int          DC    = 4;
    localparam logic [W-1:0] OUT_R = 8'h3C;
    localparam logic [W-1:0] DIR_R = 8'hC0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] gpio_i = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] gpio_oe;
    logic         irq_o;

    wb_gpio_irq_if bus ();

    wb_gpio_irq #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC),
        .DIR_RESET      (DIR_R),
        .OUT_RESET      (OUT_R)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wb     (bus.slave),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .gpio_oe(gpio_oe),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] ack_go;
    logic [W-1:0] ack_oe;
    logic         ack_irq;

    typedef struct {
        logic        we;
        int          idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    // reference model state
    logic [W-1:0] m_out, m_dir, m_mask, m_rise, m_fall, m_stat, m_din;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic bus_acc(input logic we, input logic [31:0] adr,
                           input logic [31:0] wd, output logic [31:0] rdat);
        int n;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = wd;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wb_ack_o && n < 4);
        chk("ack_latency", 32'(n), 32'd1);
        rdat    = bus.wb_dat_o;
        ack_go  = gpio_o;
        ack_oe  = gpio_oe;
        ack_irq = irq_o;
        @(posedge clk);
        #1;
        chk("ack_one_cycle", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        logic [31:0] r;
        bus_acc(1'b1, 32'(idx) << 2, d, r);
    endtask

    task automatic rd_chk(input string name, input int idx,
                          input logic [31:0] exp);
        logic [31:0] r;
        bus_acc(1'b0, 32'(idx) << 2, 32'h0, r);
        chk(name, r, exp);
    endtask

    function automatic logic [31:0] mread(input int a);
        case (a)
            0:       return {24'h0, m_din};
            1:       return {24'h0, m_out};
            2:       return {24'h0, m_dir};
            3:       return {24'h0, m_mask};
            4:       return {24'h0, m_rise};
            5:       return {24'h0, m_fall};
            6:       return {24'h0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_o", 32'(gpio_o), 32'(OUT_R));
        chk("rst_gpio_oe", 32'(gpio_oe), 32'(DIR_R));
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'd0);
        rst = 1'b0;

        vt.push_back('{1'b0, 0, 32'h0, 32'h0});
        vt.push_back('{1'b0, 1, 32'h0, 32'(OUT_R)});
        vt.push_back('{1'b0, 2, 32'h0, 32'(DIR_R)});
        vt.push_back('{1'b0, 3, 32'h0, 32'h0});
        vt.push_back('{1'b0, 4, 32'h0, 32'h0});
        vt.push_back('{1'b0, 5, 32'h0, 32'h0});
        vt.push_back('{1'b0, 6, 32'h0, 32'h0});
        vt.push_back('{1'b0, 7, 32'h0, 32'h0});
        vt.push_back('{1'b1, 1, 32'hFFFF_FFFF, 32'h0});
        vt.push_back('{1'b0, 1, 32'h0, 32'h0000_00FF});
        vt.push_back('{1'b1, 7, 32'hFFFF_FFFF, 32'h0});
        vt.push_back('{1'b0, 7, 32'h0, 32'h0});
        vt.push_back('{1'b1, 0, 32'h0000_00FF, 32'h0});
        vt.push_back('{1'b0, 0, 32'h0, 32'h0});
        vt.push_back('{1'b1, 2, 32'hFFFF_FF00, 32'h0});
        vt.push_back('{1'b0, 2, 32'h0, 32'h0});

        foreach (vt[i]) begin
            logic [31:0] r;
            bus_acc(vt[i].we, 32'(vt[i].idx) << 2, vt[i].wdata, r);
            if (!vt[i].we) chk($sformatf("vec%0d_read", i), r, vt[i].exp);
        end

        // outputs follow writes in the ack cycle
        wr(1, 32'hA5);
        chk("ack_gpio_o", 32'(ack_go), 32'hA5);
        wr(2, 32'h0F);
        chk("ack_gpio_oe", 32'(ack_oe), 32'h0F);

        // debounce latency and rising-edge interrupt on pin 2
        wr(4, 32'h04);
        wr(3, 32'h04);
        gpio_i[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("irq_before_edge5", 32'(irq_o), 32'd0);
        @(posedge clk);
        #1;
        chk("irq_after_edge5", 32'(irq_o), 32'd1);
        rd_chk("din_pin2", 0, 32'h04);
        rd_chk("status_rise2", 6, 32'h04);
        wr(6, 32'h04);
        chk("irq_after_w1c", 32'(ack_irq), 32'd0);
        rd_chk("status_cleared", 6, 32'h0);
        gpio_i[2] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rd_chk("status_no_fall", 6, 32'h0);
        rd_chk("din_fall2", 0, 32'h0);

        // short pulse is filtered
        wr(4, 32'h0C);
        wr(5, 32'h08);
        gpio_i[3] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gpio_i[3] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rd_chk("pulse_din", 0, 32'h0);
        rd_chk("pulse_status", 6, 32'h0);

        // falling edge latched while masked
        wr(5, 32'h01);
        wr(3, 32'h00);
        gpio_i[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rd_chk("status_rise0_off", 6, 32'h0);
        gpio_i[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rd_chk("status_fall0", 6, 32'h01);
        chk("irq_masked", 32'(irq_o), 32'd0);
        wr(3, 32'h01);
        chk("irq_unmasked", 32'(ack_irq), 32'd1);

        // clear of bit 1 collides with its set; bit 0 clears normally
        wr(4, 32'h02);
        gpio_i[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        wr(6, 32'h03);
        rd_chk("set_beats_clear", 6, 32'h02);
        chk("irq_after_collide", 32'(irq_o), 32'd0);

        // read concurrent with a set sees the old value
        wr(4, 32'h06);
        gpio_i[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd_chk("read_pre_set", 6, 32'h02);
        rd_chk("read_post_set", 6, 32'h06);

        // reset in the middle of an acked access
        gpio_i = '0;
        repeat (8) @(posedge clk);
        #1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h4;
        bus.wb_dat_i = 32'h11;
        @(posedge clk);
        #1;
        chk("midrst_ack", 32'(bus.wb_ack_o), 32'd1);
        chk("midrst_gpio_o", 32'(gpio_o), 32'h11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ack_drop", 32'(bus.wb_ack_o), 32'd0);
        chk("midrst_gpio_o_rst", 32'(gpio_o), 32'(OUT_R));
        chk("midrst_gpio_oe_rst", 32'(gpio_oe), 32'(DIR_R));
        chk("midrst_irq", 32'(irq_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        rst = 1'b0;
        rd_chk("midrst_status", 6, 32'h0);
        rd_chk("midrst_mask", 3, 32'h0);
        rd_chk("midrst_rise", 4, 32'h0);
        rd_chk("midrst_fall", 5, 32'h0);
        rd_chk("midrst_dir", 2, 32'(DIR_R));
        rd_chk("midrst_out", 1, 32'(OUT_R));

        // random traffic against the reference model
        m_out  = OUT_R;
        m_dir  = DIR_R;
        m_mask = '0;
        m_rise = '0;
        m_fall = '0;
        m_stat = '0;
        m_din  = '0;
        for (int it = 0; it < 150; it++) begin
            int          op;
            int          a;
            logic [31:0] d;
            logic [31:0] adr;
            logic [31:0] r;
            logic [W-1:0] nv;
            op  = int'($urandom_range(0, 2));
            a   = int'($urandom_range(0, 7));
            d   = $urandom;
            adr = ($urandom & 32'hFFFF_FFE3) | (32'(a) << 2);
            if (op == 0) begin
                bus_acc(1'b1, adr, d, r);
                case (a)
                    1: m_out  = d[W-1:0];
                    2: m_dir  = d[W-1:0];
                    3: m_mask = d[W-1:0];
                    4: m_rise = d[W-1:0];
                    5: m_fall = d[W-1:0];
                    6: m_stat = m_stat & ~d[W-1:0];
                    default: ;
                endcase
                chk("rnd_gpio_o", 32'(ack_go), 32'(m_out));
                chk("rnd_gpio_oe", 32'(ack_oe), 32'(m_dir));
                chk("rnd_ack_irq", 32'(ack_irq), 32'(|(m_stat & m_mask)));
            end else if (op == 1) begin
                bus_acc(1'b0, adr, 32'h0, r);
                chk($sformatf("rnd_read_a%0d", a), r, mread(a));
            end else begin
                nv     = W'($urandom);
                gpio_i = nv;
                repeat (8) @(posedge clk);
                #1;
                m_stat = m_stat | (nv & ~m_din & m_rise)
                                | (~nv & m_din & m_fall);
                m_din  = nv;
                chk("rnd_irq", 32'(irq_o), 32'(|(m_stat & m_mask)));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
